mem_port_arbiter: RTL and testbench

Two-port, non-preemptive arbiter between the data-side and instruction-side encryption/MAC units and the single 128-bit line BRAM. It replaces the inline arbitration logic in the platform top. Each transaction is one line read or write, serialized onto the memory port with request/valid handshakes. Data has priority, instruction fetches have a starvation guard, and a timeout protects against a memory that never responds.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Non-preemptive two-port arbiter serializing data-side and instruction-side line
// transactions onto a single 128-bit BRAM port, with a starvation guard and a response timeout.
module mem_port_arbiter #(
    parameter int ADDR_BITS      = 16,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 sys_clock,
    input  logic                 reset,
    input  logic                 d_req,
    input  logic                 d_write,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [127:0]         d_wdata,
    output logic                 d_rdy,
    input  logic                 i_req,
    input  logic                 i_write,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [127:0]         i_wdata,
    output logic                 i_rdy,
    output logic [127:0]         rdata,
    output logic                 err,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [127:0]         mem_wdata,
    input  logic [127:0]         mem_rdata,
    input  logic                 mem_valid,
    output logic [1:0]           dbg_state
);

    // Handshake: a port holds req (and stable write/addr/wdata) until its rdy pulses for one
    // cycle; the memory sees a one-cycle mem_req and answers with a one-cycle mem_valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

    state_t                 state, state_next;
    logic [3:0]             starve_cnt, starve_next;
    logic [7:0]             tcnt, tcnt_next;
    logic                   gnt_inst, gnt_inst_next;
    logic                   take_inst;
    logic                   d_rdy_next, i_rdy_next, err_next;
    logic                   mem_req_next, mem_write_next;
    logic [ADDR_BITS-1:0]   mem_addr_next;
    logic [127:0]           mem_wdata_next, rdata_next;

    assign dbg_state = state;

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            tcnt       <= 8'd0;
            gnt_inst   <= 1'b0;
            d_rdy      <= 1'b0;
            i_rdy      <= 1'b0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            tcnt       <= tcnt_next;
            gnt_inst   <= gnt_inst_next;
            d_rdy      <= d_rdy_next;
            i_rdy      <= i_rdy_next;
            err        <= err_next;
            mem_req    <= mem_req_next;
            mem_write  <= mem_write_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            rdata      <= rdata_next;
        end
    end

    always_comb begin
        state_next     = state;
        starve_next    = starve_cnt;
        tcnt_next      = tcnt;
        gnt_inst_next  = gnt_inst;
        take_inst      = 1'b0;
        d_rdy_next     = 1'b0;
        i_rdy_next     = 1'b0;
        err_next       = 1'b0;
        mem_req_next   = 1'b0;
        mem_write_next = mem_write;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        rdata_next     = rdata;

        case (state)
            IDLE: begin
                if (!i_req) starve_next = 4'd0;
                if (d_req || i_req) begin
                    take_inst      = i_req && (!d_req || (starve_cnt >= STARVE_LIM));
                    gnt_inst_next  = take_inst;
                    mem_req_next   = 1'b1;
                    mem_write_next = take_inst ? i_write : d_write;
                    mem_addr_next  = take_inst ? i_addr  : d_addr;
                    mem_wdata_next = take_inst ? i_wdata : d_wdata;
                    tcnt_next      = 8'd0;
                    state_next     = ISSUE;
                    // Only data grants that bypass a waiting inst request count toward starvation.
                    if (take_inst) begin
                        starve_next = 4'd0;
                    end else if (i_req && (starve_cnt != 4'hF)) begin
                        starve_next = starve_cnt + 4'd1;
                    end
                end
            end
            ISSUE: begin
                if (mem_valid) begin
                    rdata_next = mem_rdata;
                    d_rdy_next = !gnt_inst;
                    i_rdy_next = gnt_inst;
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // mem_valid is checked first so a reply on the expiry cycle is not reported as an error.
                if (mem_valid) begin
                    rdata_next = mem_rdata;
                    d_rdy_next = !gnt_inst;
                    i_rdy_next = gnt_inst;
                    state_next = RESP;
                end else if (tcnt == TO_LAST) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    d_rdy_next = !gnt_inst;
                    i_rdy_next = gnt_inst;
                    state_next = RESP;
                end else begin
                    tcnt_next = tcnt + 8'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 1-cycle BRAM model plus hand-placed mem_valid
// pulses cover latency, writes, starvation pattern, timeout, coincidence and reset abort.
module tb_mem_port_arbiter;

    logic         sys_clock = 1'b0;
    logic         reset = 1'b1;
    logic         d_req = 1'b0, d_write = 1'b0;
    logic [15:0]  d_addr = '0;
    logic [127:0] d_wdata = '0;
    logic         d_rdy;
    logic         i_req = 1'b0, i_write = 1'b0;
    logic [15:0]  i_addr = '0;
    logic [127:0] i_wdata = '0;
    logic         i_rdy;
    logic [127:0] rdata;
    logic         err;
    logic         mem_req, mem_write;
    logic [15:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_valid;
    logic [1:0]   dbg_state;

    logic         bram_mode = 1'b0;
    logic         bram_valid = 1'b0;
    logic         man_valid = 1'b0;
    logic [127:0] bram_line = '0;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2;

    mem_port_arbiter #(
        .ADDR_BITS(16), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .sys_clock(sys_clock), .reset(reset),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdy(d_rdy),
        .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata), .i_rdy(i_rdy),
        .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 sys_clock = ~sys_clock;

    // 1-cycle BRAM: answers the cycle after it sees mem_req
    always @(posedge sys_clock) bram_valid <= bram_mode && mem_req;
    assign mem_valid = bram_valid | man_valid;
    assign mem_rdata = bram_line;

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".d_rdy"},     128'(d_rdy),     128'd0);
        chk({tag, ".i_rdy"},     128'(i_rdy),     128'd0);
        chk({tag, ".err"},       128'(err),       128'd0);
        chk({tag, ".mem_req"},   128'(mem_req),   128'd0);
        chk({tag, ".mem_write"}, 128'(mem_write), 128'd0);
        chk({tag, ".mem_addr"},  128'(mem_addr),  128'd0);
        chk({tag, ".mem_wdata"}, mem_wdata,       128'd0);
        chk({tag, ".rdata"},     rdata,           128'd0);
        chk({tag, ".state"},     128'(dbg_state), 128'(S_IDLE));
    endtask

    // driver: one complete transaction on one port, checked against hand-computed values
    task automatic txn(input string tag, input logic inst, input logic wr, input logic [15:0] addr,
                       input logic [127:0] wd, input logic [127:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int valid_at);
        int n, req_cnt;
        logic got, other_rdy, seen_wr;
        logic [15:0] seen_addr;
        logic [127:0] seen_wd;
        n = 0; req_cnt = 0; got = 1'b0; other_rdy = 1'b0;
        seen_wr = 1'b0; seen_addr = '0; seen_wd = '0;
        if (inst) begin
            i_req = 1'b1; i_write = wr; i_addr = addr; i_wdata = wd;
        end else begin
            d_req = 1'b1; d_write = wr; d_addr = addr; d_wdata = wd;
        end
        while (!got && n < 400) begin
            step();
            n++;
            man_valid = (n == valid_at);
            if (mem_req) begin
                req_cnt++;
                seen_wr = mem_write; seen_addr = mem_addr; seen_wd = mem_wdata;
            end
            if (inst ? d_rdy : i_rdy) other_rdy = 1'b1;
            if (inst ? i_rdy : d_rdy) got = 1'b1;
        end
        man_valid = 1'b0;
        chk({tag, ".rdy_seen"},  128'(got),       128'd1);
        chk({tag, ".latency"},   128'(n),         128'(exp_lat));
        chk({tag, ".rdata"},     rdata,           exp_rd);
        chk({tag, ".err"},       128'(err),       128'(exp_err));
        chk({tag, ".mem_req_n"}, 128'(req_cnt),   128'd1);
        chk({tag, ".mem_addr"},  128'(seen_addr), 128'(addr));
        chk({tag, ".mem_write"}, 128'(seen_wr),   128'(wr));
        chk({tag, ".mem_wdata"}, seen_wd,         wd);
        chk({tag, ".other_rdy"}, 128'(other_rdy), 128'd0);
        d_req = 1'b0; i_req = 1'b0;
        step();
        chk({tag, ".rdy_pulse"}, 128'(d_rdy | i_rdy), 128'd0);
        chk({tag, ".back_idle"}, 128'(dbg_state),     128'(S_IDLE));
    endtask

    initial begin : main
        int ev, cyc;
        logic both;
        logic [9:0] seq;

        reset = 1'b1;
        repeat (3) step();
        chk_reset_outputs("reset_hold");
        reset = 1'b0;
        step();
        chk_reset_outputs("reset_release");

        // single data read, 1-cycle BRAM
        bram_mode = 1'b1;
        bram_line = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        txn("d_read", 1'b0, 1'b0, 16'h0012, '0,
            128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 3, 0);

        // data write, all-ones line; read data is captured on writes too
        bram_line = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        txn("d_write", 1'b0, 1'b1, 16'h03FF, {128{1'b1}},
            128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0, 3, 0);

        // mem_valid already during ISSUE skips WAIT
        bram_mode = 1'b0;
        bram_line = 128'h11111111_22222222_33333333_44444444;
        txn("i_issue_valid", 1'b1, 1'b0, 16'h0040, '0,
            128'h11111111_22222222_33333333_44444444, 1'b0, 2, 1);

        // both ports held high: DDDDI DDDDI, one transaction per 4 cycles
        bram_mode = 1'b1;
        d_write = 1'b0; i_write = 1'b0; d_addr = 16'h0100; i_addr = 16'h0200;
        d_req = 1'b1; i_req = 1'b1;
        ev = 0; cyc = 0; both = 1'b0; seq = '0;
        while (ev < 10 && cyc < 100) begin
            step();
            cyc++;
            if (d_rdy && i_rdy) both = 1'b1;
            if (d_rdy || i_rdy) begin
                seq[ev] = i_rdy;
                ev++;
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        chk("starve.events",  128'(ev),   128'd10);
        chk("starve.order",   128'(seq),  128'(10'b10_0001_0000));
        chk("starve.both",    128'(both), 128'd0);
        chk("starve.cycles",  128'(cyc),  128'd39);
        repeat (2) step();

        // timeout: no mem_valid, TIMEOUT_CYCLES=8 -> rdy/err at k+10
        bram_mode = 1'b0;
        txn("i_timeout", 1'b1, 1'b0, 16'h0055, '0, 128'd0, 1'b1, 10, 0);

        // next transaction completes normally
        bram_mode = 1'b1;
        bram_line = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        txn("d_after_to", 1'b0, 1'b0, 16'h0077, '0,
            128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1'b0, 3, 0);

        // mem_valid on the expiry cycle wins over timeout
        bram_mode = 1'b0;
        bram_line = 128'h0BADC0DE_0BADC0DE_12345678_9ABCDEF0;
        txn("i_coincident", 1'b1, 1'b0, 16'h0066, '0,
            128'h0BADC0DE_0BADC0DE_12345678_9ABCDEF0, 1'b0, 10, 9);

        // reset during WAIT of an inst read, then a stray mem_valid
        i_write = 1'b0; i_addr = 16'h00AB; i_wdata = '0; i_req = 1'b1;
        step();
        chk("rst_mid.issue", 128'(mem_req), 128'd1);
        step();
        step();
        chk("rst_mid.wait", 128'(dbg_state), 128'(S_WAIT));
        reset = 1'b1;
        i_req = 1'b0;
        step();
        chk_reset_outputs("rst_mid.in_reset");
        reset = 1'b0;
        step();
        man_valid = 1'b1;
        step();
        man_valid = 1'b0;
        chk("rst_mid.no_i_rdy", 128'(i_rdy), 128'd0);
        step();
        chk_reset_outputs("rst_mid.after_stray");

        bram_mode = 1'b1;
        bram_line = 128'hFEEDFACE_00000001_00000002_00000003;
        txn("d_after_rst", 1'b0, 1'b0, 16'h0123, '0,
            128'hFEEDFACE_00000001_00000002_00000003, 1'b0, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
